// File: rtl/swd_xfer_ctl_pkg.sv
// Shared SWD constants: acknowledge codes understood by the bit engine and command
// controller, sequencer state encodings and the latched request layout.
package swd_xfer_ctl_pkg;

    localparam logic [2:0] ACK_OK    = 3'b001;
    localparam logic [2:0] ACK_WAIT  = 3'b010;
    localparam logic [2:0] ACK_FAULT = 3'b100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;

    typedef struct packed {
        logic        apndp;
        logic        rnw;
        logic [1:0]  addr32;
        logic [31:0] wdata;
    } swd_req_t;

    function automatic logic ack_is_ok(input logic [2:0] ack);
        return ack == ACK_OK;
    endfunction

    function automatic logic ack_is_wait(input logic [2:0] ack);
        return ack == ACK_WAIT;
    endfunction

endpackage

// File: rtl/swd_xfer_ctl.sv
// SWD transfer sequencer: one DP/AP command in, engine frame(s) with WAIT retry, one result out.
// Latency: go one clock after accept; rsp_valid two clocks after the final engine idle.
// Backpressure: cmd_ready only in IDLE; result held stable in RESP until rsp_ready.
module swd_xfer_ctl
    import swd_xfer_ctl_pkg::*;
#(
    parameter int MAXRETRY_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MAXRETRY_W-1:0] wait_retries,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_apndp,
    input  logic                  cmd_rnw,
    input  logic [1:0]            cmd_addr32,
    input  logic [31:0]           cmd_wdata,
    input  logic                  abort,
    output logic                  if_go,
    output logic                  if_apndp,
    output logic                  if_rnw,
    output logic [1:0]            if_addr32,
    output logic [31:0]           if_dwrite,
    input  logic                  if_idle,
    input  logic [2:0]            if_ack,
    input  logic [31:0]           if_dread,
    input  logic                  if_perr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [2:0]            rsp_ack,
    output logic [31:0]           rsp_data,
    output logic                  rsp_perr,
    output logic [MAXRETRY_W-1:0] rsp_retries
);

    logic [2:0]            state;
    swd_req_t              req;
    logic [MAXRETRY_W-1:0] limit;
    logic [MAXRETRY_W-1:0] retries;
    logic                  retry_ok;

    // retries only advances while strictly below limit, so it can never wrap
    assign retry_ok = ack_is_wait(if_ack) && (retries < limit) && !abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            req      <= '0;
            limit    <= '0;
            retries  <= '0;
            rsp_ack  <= 3'b000;
            rsp_data <= 32'h0;
            rsp_perr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        req.apndp  <= cmd_apndp;
                        req.rnw    <= cmd_rnw;
                        req.addr32 <= cmd_addr32;
                        req.wdata  <= cmd_wdata;
                        limit      <= wait_retries;
                        retries    <= '0;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // engine acknowledges go by leaving idle; only then is the frame ours
                    if (!if_idle) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (if_idle) begin
                        state <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    rsp_ack <= if_ack;
                    if (ack_is_ok(if_ack)) begin
                        rsp_data <= req.rnw ? if_dread : 32'h0;
                        rsp_perr <= req.rnw ? if_perr : 1'b0;
                        state    <= ST_RESP;
                    end else if (retry_ok) begin
                        retries <= retries + MAXRETRY_W'(1);
                        state   <= ST_ISSUE;
                    end else begin
                        rsp_data <= 32'h0;
                        rsp_perr <= 1'b0;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready   = (state == ST_IDLE);
    assign if_go       = (state == ST_ISSUE);
    assign rsp_valid   = (state == ST_RESP);
    assign rsp_retries = retries;

    assign if_apndp  = req.apndp;
    assign if_rnw    = req.rnw;
    assign if_addr32 = req.addr32;
    assign if_dwrite = req.wdata;

endmodule

// File: tb/tb_swd_xfer_ctl.sv
// Randomized bench for swd_xfer_ctl: behavioural bit-engine model driven from a per-command
// ack script, results compared against a frame-level retry model.
module tb_swd_xfer_ctl;
    import swd_xfer_ctl_pkg::*;

    localparam int MW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [MW-1:0] wait_retries = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_apndp = 1'b0;
    logic          cmd_rnw = 1'b0;
    logic [1:0]    cmd_addr32 = 2'b00;
    logic [31:0]   cmd_wdata = 32'h0;
    logic          abort = 1'b0;
    logic          if_go;
    logic          if_apndp;
    logic          if_rnw;
    logic [1:0]    if_addr32;
    logic [31:0]   if_dwrite;
    logic          if_idle = 1'b1;
    logic [2:0]    if_ack = 3'b000;
    logic [31:0]   if_dread = 32'h0;
    logic          if_perr = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [2:0]    rsp_ack;
    logic [31:0]   rsp_data;
    logic          rsp_perr;
    logic [MW-1:0] rsp_retries;

    swd_xfer_ctl #(.MAXRETRY_W(MW)) dut (
        .clk(clk), .rst(rst), .wait_retries(wait_retries),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_apndp(cmd_apndp),
        .cmd_rnw(cmd_rnw), .cmd_addr32(cmd_addr32), .cmd_wdata(cmd_wdata),
        .abort(abort), .if_go(if_go), .if_apndp(if_apndp), .if_rnw(if_rnw),
        .if_addr32(if_addr32), .if_dwrite(if_dwrite), .if_idle(if_idle),
        .if_ack(if_ack), .if_dread(if_dread), .if_perr(if_perr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ack(rsp_ack),
        .rsp_data(rsp_data), .rsp_perr(rsp_perr), .rsp_retries(rsp_retries)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_miscmp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Engine script: per-frame ack/data/perr; frames past the script answer WAIT
    logic [2:0]  s_ack[8];
    logic [31:0] s_data[8];
    logic        s_perr[8];
    int          s_len = 0;

    int          frames = 0;
    int          busy = 0;
    int          e_idx = 0;
    int          eng_idle_cyc = 0;
    int          field_bad = 0;
    bit          go_q = 1'b0;
    bit          abort_arm = 1'b0;
    logic [35:0] exp_fields = '0;

    always @(negedge clk) begin
        if (rst) begin
            if_idle = 1'b1;
            busy    = 0;
            go_q    = 1'b0;
        end else begin
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    e_idx = frames - 1;
                    if (e_idx < s_len) begin
                        if_ack   = s_ack[e_idx];
                        if_dread = s_data[e_idx];
                        if_perr  = s_perr[e_idx];
                    end else begin
                        if_ack   = ACK_WAIT;
                        if_dread = 32'h0;
                        if_perr  = 1'b0;
                    end
                    if_idle      = 1'b1;
                    eng_idle_cyc = cyc;
                end
            end else if (if_go && !go_q) begin
                frames++;
                if_idle  = 1'b0;
                if_ack   = 3'b000;
                if_dread = $urandom;
                if_perr  = 1'($urandom);
                busy     = $urandom_range(1, 5);
                if ({if_apndp, if_rnw, if_addr32, if_dwrite} !== exp_fields) field_bad++;
                if (abort_arm) abort = 1'b1;
            end
            go_q = if_go;
        end
    end

    task automatic put(input int i, input logic [2:0] a, input logic [31:0] d, input logic p);
        s_ack[i]  = a;
        s_data[i] = d;
        s_perr[i] = p;
    endtask

    task automatic run_cmd(input bit apndp, input bit rnw, input logic [1:0] addr,
                           input logic [31:0] wd, input logic [MW-1:0] lim,
                           input bit ab_arm, input bit ab_pre, input int rdy_dly);
        int          ef;
        logic [2:0]  ea;
        logic [31:0] ed;
        logic        ep;
        int          t;
        int          stall_bad;
        // frame-level model: keep issuing while WAIT, attempts-so-far <= limit and no abort
        ef = 0;
        do begin
            ea = (ef < s_len) ? s_ack[ef] : ACK_WAIT;
            ef++;
        end while (ea == ACK_WAIT && (ef - 1) < int'(lim) && !(ab_arm || ab_pre));
        ed = (ea == ACK_OK && rnw) ? s_data[ef-1] : 32'h0;
        ep = (ea == ACK_OK && rnw) ? s_perr[ef-1] : 1'b0;

        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        frames       = 0;
        field_bad    = 0;
        exp_fields   = {apndp, rnw, addr, wd};
        abort_arm    = ab_arm;
        abort        = ab_pre;
        cmd_apndp    = apndp;
        cmd_rnw      = rnw;
        cmd_addr32   = addr;
        cmd_wdata    = wd;
        wait_retries = lim;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid    = 1'b0;
        wait_retries = MW'($urandom);
        cmd_wdata    = $urandom;
        cmd_apndp    = 1'($urandom);
        chk("if_go_rise", if_go, 1);

        t = 0;
        while (!rsp_valid && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("rsp_valid_wait", rsp_valid, 1);
        chk("turnaround", 64'(cyc - eng_idle_cyc), 2);
        chk("rsp_ack", rsp_ack, ea);
        chk("rsp_data", rsp_data, ed);
        chk("rsp_perr", rsp_perr, ep);
        chk("rsp_retries", rsp_retries, ef - 1);
        chk("frames", frames, ef);
        chk("req_fields_stable", field_bad, 0);

        stall_bad = 0;
        for (int i = 0; i < rdy_dly; i++) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            if (!rsp_valid || cmd_ready || rsp_ack !== ea || rsp_data !== ed ||
                rsp_perr !== ep || rsp_retries !== MW'(ef - 1)) stall_bad++;
        end
        if (rdy_dly > 0) chk("stall_stable", stall_bad, 0);

        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_done_valid", rsp_valid, 0);
        chk("rsp_done_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        abort     = 1'b0;
        abort_arm = 1'b0;
    endtask

    initial begin
        int          t;
        int          r;
        logic [2:0]  a;
        #2;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_if_go", if_go, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_fields", {rsp_ack, rsp_data, rsp_perr, rsp_retries}, 0);
        chk("rst_if_fields", {if_apndp, if_rnw, if_addr32, if_dwrite}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        s_len = 1; put(0, ACK_OK, 32'h2BA01477, 1'b0);
        run_cmd(1'b0, 1'b1, 2'b00, 32'h0, 16'd0, 1'b0, 1'b0, 0);

        s_len = 3;
        put(0, ACK_WAIT, 32'h1111_1111, 1'b1);
        put(1, ACK_WAIT, 32'h2222_2222, 1'b0);
        put(2, ACK_OK,   32'h3333_3333, 1'b1);
        run_cmd(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 16'd5, 1'b0, 1'b0, 1);

        s_len = 0;
        run_cmd(1'b1, 1'b1, 2'b11, 32'h0, 16'd3, 1'b0, 1'b0, 0);

        s_len = 1; put(0, ACK_FAULT, 32'hAAAA_5555, 1'b1);
        run_cmd(1'b1, 1'b1, 2'b10, 32'h0, 16'd5, 1'b0, 1'b0, 0);
        s_len = 1; put(0, 3'b111, 32'hFFFF_FFFF, 1'b1);
        run_cmd(1'b0, 1'b1, 2'b01, 32'h0, 16'd5, 1'b0, 1'b0, 0);

        s_len = 1; put(0, ACK_OK, 32'h0BAD_F00D, 1'b1);
        run_cmd(1'b1, 1'b1, 2'b00, 32'h0, 16'd4, 1'b0, 1'b0, 10);

        s_len = 0;
        run_cmd(1'b1, 1'b1, 2'b00, 32'h0, 16'd8, 1'b1, 1'b0, 0);

        s_len = 4;
        put(0, ACK_WAIT, 32'h0, 1'b0);
        put(1, ACK_WAIT, 32'h0, 1'b0);
        put(2, ACK_WAIT, 32'h0, 1'b0);
        put(3, ACK_OK, 32'hCAFE_0001, 1'b0);
        run_cmd(1'b0, 1'b1, 2'b10, 32'h0, 16'hFFFF, 1'b0, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            s_len = $urandom_range(1, 6);
            for (int i = 0; i < s_len; i++) begin
                r = $urandom_range(0, 9);
                if (r < 4)      a = ACK_OK;
                else if (r < 8) a = ACK_WAIT;
                else if (r < 9) a = ACK_FAULT;
                else            a = 3'($urandom);
                put(i, a, $urandom, ($urandom_range(0, 3) == 0));
            end
            run_cmd(1'($urandom), 1'($urandom), 2'($urandom), $urandom,
                    MW'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
        end

        // async reset while the engine frame is in flight
        s_len = 1; put(0, ACK_OK, 32'h1234_5678, 1'b0);
        @(negedge clk);
        exp_fields = {1'b1, 1'b0, 2'b11, 32'h5A5A_A5A5};
        frames = 0;
        cmd_apndp = 1'b1; cmd_rnw = 1'b0; cmd_addr32 = 2'b11; cmd_wdata = 32'h5A5A_A5A5;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (if_idle && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("eng_busy_before_rst", if_idle, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_if_go", if_go, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", cmd_ready, 1);
        chk("post_rst_if_go", if_go, 0);
        chk("post_rst_fields", {if_dwrite, rsp_retries, rsp_ack}, 0);

        s_len = 2; put(0, ACK_WAIT, 32'h0, 1'b0); put(1, ACK_OK, 32'h7777_8888, 1'b0);
        run_cmd(1'b0, 1'b1, 2'b01, 32'h0, 16'd1, 1'b0, 1'b0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
